// File: rtl/mult_prod_accum.sv
// mult_prod_accum: shifts each limb product to its column and sums it into a
// wide accumulator, then presents the finished product under valid/ready.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   i_prod   2*BITS product from the limb multiplier
//   i_shift  column offset in limbs (weight 2^(i_shift*BITS))
//   i_val    i_prod/i_shift/i_last valid
//   i_last   final product of the current multiplication
//   o_rdy    block accepts a product this cycle (registered)
//   o_dat    accumulated result (registered)
//   o_val    o_dat valid (registered)
//   i_rdy    downstream accepts o_dat
//   o_err    sticky out-of-range shift flag (registered)
module mult_prod_accum #(
   parameter int unsigned BITS     = 17,
   parameter int unsigned NUM_WRDS = 4,
   parameter int unsigned GUARD    = 4,
   parameter int unsigned RES_BITS = 2*NUM_WRDS*BITS + GUARD,
   parameter int unsigned SHW      = $clog2(2*NUM_WRDS)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [2*BITS-1:0]   i_prod,
   input  logic [SHW-1:0]      i_shift,
   input  logic                i_val,
   input  logic                i_last,
   output logic                o_rdy,
   output logic [RES_BITS-1:0] o_dat,
   output logic                o_val,
   input  logic                i_rdy,
   output logic                o_err
);

   localparam int unsigned MAX_SHIFT = 2*NUM_WRDS - 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t              state;
   logic [RES_BITS-1:0] acc;
   logic [RES_BITS-1:0] prod_ext;
   logic [RES_BITS-1:0] term;
   logic                beat_ok;
   logic                shift_bad;

   // Column-aligned term; an out-of-range shift contributes nothing.
   always_comb begin
      prod_ext  = RES_BITS'(i_prod);
      shift_bad = 32'(i_shift) > MAX_SHIFT;
      beat_ok   = i_val & o_rdy;
      term      = '0;
      if (!shift_bad)
         term = prod_ext << (32'(i_shift) * BITS);
   end

   // The accumulator register doubles as the output data register.
   assign o_dat = acc;

   // Control FSM; o_rdy depends only on state so i_rdy never reaches it
   // combinationally.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ST_IDLE;
         acc   <= '0;
         o_val <= 1'b0;
         o_rdy <= 1'b0;
         o_err <= 1'b0;
      end else begin
         if (beat_ok && shift_bad)
            o_err <= 1'b1;

         case (state)
            ST_IDLE: begin
               o_rdy <= 1'b1;
               if (beat_ok) begin
                  acc <= term;
                  if (i_last) begin
                     state <= ST_HOLD;
                     o_rdy <= 1'b0;
                     o_val <= 1'b1;
                  end else begin
                     state <= ST_ACCUM;
                  end
               end
            end

            ST_ACCUM: begin
               o_rdy <= 1'b1;
               if (beat_ok) begin
                  acc <= acc + term;
                  if (i_last) begin
                     state <= ST_HOLD;
                     o_rdy <= 1'b0;
                     o_val <= 1'b1;
                  end
               end
            end

            ST_HOLD: begin
               if (i_rdy) begin
                  acc   <= '0;
                  o_val <= 1'b0;
                  o_rdy <= 1'b1;
                  state <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
               acc   <= '0;
               o_val <= 1'b0;
               o_rdy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_prod_accum.sv
// Directed bench for mult_prod_accum with BITS=17, NUM_WRDS=2 (72-bit result).
module tb_mult_prod_accum;

   localparam int unsigned BITS     = 17;
   localparam int unsigned NUM_WRDS = 2;
   localparam int unsigned RES_BITS = 2*NUM_WRDS*BITS + 4;
   localparam int unsigned SHW      = $clog2(2*NUM_WRDS);

   logic                clk = 1'b0;
   logic                rst;
   logic [2*BITS-1:0]   prod;
   logic [SHW-1:0]      shift;
   logic                val;
   logic                last;
   logic                rdy_out;
   logic [RES_BITS-1:0] dat;
   logic                val_out;
   logic                rdy_in;
   logic                err;

   int n_vec = 0;
   int n_err = 0;

   mult_prod_accum #(
      .BITS     (BITS),
      .NUM_WRDS (NUM_WRDS)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_prod  (prod),
      .i_shift (shift),
      .i_val   (val),
      .i_last  (last),
      .o_rdy   (rdy_out),
      .o_dat   (dat),
      .o_val   (val_out),
      .i_rdy   (rdy_in),
      .o_err   (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [2*BITS-1:0] p, input logic [SHW-1:0] s, input logic l);
      val   = 1'b1;
      prod  = p;
      shift = s;
      last  = l;
      tick();
      val   = 1'b0;
      last  = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [127:0] d, input logic v, input logic r, input logic e);
      chk({tag, "_dat"}, 128'(dat), d);
      chk({tag, "_val"}, 128'(val_out), 128'(v));
      chk({tag, "_rdy"}, 128'(rdy_out), 128'(r));
      chk({tag, "_err"}, 128'(err), 128'(e));
   endtask

   initial begin
      rst    = 1'b1;
      prod   = '0;
      shift  = '0;
      val    = 1'b0;
      last   = 1'b0;
      rdy_in = 1'b1;
      tick();
      tick();
      chk_out("reset", 128'd0, 1'b0, 1'b0, 1'b0);

      rst = 1'b0;
      tick();
      chk_out("rdy_after_reset", 128'd0, 1'b0, 1'b1, 1'b0);

      // Two back-to-back beats, downstream ready
      beat(34'd3, 2'd0, 1'b0);
      chk("t1_not_val", 128'(val_out), 128'd0);
      beat(34'd5, 2'd1, 1'b1);
      chk_out("t1_hold", 128'd655363, 1'b1, 1'b0, 1'b0);
      tick();
      chk_out("t1_done", 128'd0, 1'b0, 1'b1, 1'b0);

      // Schoolbook (7 + 2*2^17) * (9 + 2^17)
      beat(34'd63, 2'd0, 1'b0);
      beat(34'd7,  2'd1, 1'b0);
      beat(34'd18, 2'd1, 1'b0);
      beat(34'd2,  2'd2, 1'b1);
      chk_out("t2_hold", 128'd34363015231, 1'b1, 1'b0, 1'b0);
      tick();
      chk_out("t2_done", 128'd0, 1'b0, 1'b1, 1'b0);

      // Backpressure: stalled beats must be ignored
      rdy_in = 1'b0;
      beat(34'd10, 2'd0, 1'b1);
      chk_out("t3_hold", 128'd10, 1'b1, 1'b0, 1'b0);
      val   = 1'b1;
      prod  = 34'd100;
      shift = 2'd0;
      last  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_out("t3_stall", 128'd10, 1'b1, 1'b0, 1'b0);
      end
      val    = 1'b0;
      rdy_in = 1'b1;
      tick();
      chk_out("t3_release", 128'd0, 1'b0, 1'b1, 1'b0);
      tick();
      chk("t3_single_xfer", 128'(val_out), 128'd0);
      beat(34'd1, 2'd0, 1'b1);
      chk_out("t3_fresh", 128'd1, 1'b1, 1'b0, 1'b0);
      tick();

      // Top column, full-scale product: guard bits stay clear
      beat(34'h3_FFFF_FFFF, 2'd2, 1'b1);
      chk_out("t4_top", 128'h3_FFFF_FFFF << 34, 1'b1, 1'b0, 1'b0);
      chk("t4_guard", 128'(dat[RES_BITS-1 -: 4]), 128'd0);
      tick();

      // Illegal shift: term dropped, error sticky
      beat(34'd4, 2'd0, 1'b0);
      beat(34'd9, 2'd3, 1'b0);
      chk_out("t5_bad", 128'd4, 1'b0, 1'b1, 1'b1);
      beat(34'd6, 2'd1, 1'b1);
      chk_out("t5_hold", 128'd786436, 1'b1, 1'b0, 1'b1);
      tick();
      beat(34'd1, 2'd0, 1'b1);
      chk_out("t5_sticky", 128'd1, 1'b1, 1'b0, 1'b1);
      tick();

      // Illegal shift as the last beat still completes
      beat(34'd9, 2'd3, 1'b1);
      chk_out("t5_bad_last", 128'd0, 1'b1, 1'b0, 1'b1);
      tick();

      // Reset in ACCUM
      beat(34'd3, 2'd0, 1'b0);
      beat(34'd5, 2'd1, 1'b0);
      chk("t6_partial", 128'(dat), 128'd655363);
      rst = 1'b1;
      tick();
      chk_out("t6_rst_accum", 128'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      chk("t6_rdy_back", 128'(rdy_out), 128'd1);

      // Reset in HOLD with an error pending
      rdy_in = 1'b0;
      beat(34'd7, 2'd3, 1'b1);
      chk_out("t6_hold", 128'd0, 1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      tick();
      chk_out("t6_rst_hold", 128'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      rdy_in = 1'b1;
      tick();
      beat(34'd2, 2'd0, 1'b0);
      beat(34'd3, 2'd2, 1'b1);
      chk_out("t6_clean", 128'd51539607554, 1'b1, 1'b0, 1'b0);
      tick();
      chk_out("t6_done", 128'd0, 1'b0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
